// File: rtl/l1_block_cache_mp.sv
// -----------------------------------------------------------------------------
// l1_block_cache_mp
//
// Multi-port, direct-mapped L1 cache of world block types, keyed by block
// position. Each lookup port holds one outstanding request. A pending port
// looks the cache up every cycle until it hits. Misses are funnelled
// round-robin into a single backing-store fetch, one at a time. World edits
// update resident lines in place. Saturating counters track hits and issued
// fetches.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-high reset
//   req_valid/req_pos         per-port lookup request (port p at [p*POS_W +: POS_W])
//   req_ready                 port is idle and can take a request
//   resp_valid/resp_type      1-cycle response pulse with the block type
//   mem_req_valid/_ready/_pos backing-store fetch request channel
//   mem_resp_valid/_type      fetched block type (1-cycle pulse)
//   upd_valid/_pos/_type      world edit: overwrite a resident block
//   hit_count, miss_count     saturating statistics
// -----------------------------------------------------------------------------
module l1_block_cache_mp #(
   parameter int NUM_PORTS = 4,
   parameter int POS_W     = 16,
   parameter int TYPE_W    = 4,
   parameter int IDX_W     = 6,
   parameter int CNT_W     = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [NUM_PORTS-1:0]        req_valid,
   input  logic [NUM_PORTS*POS_W-1:0]  req_pos,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic [NUM_PORTS-1:0]        resp_valid,
   output logic [NUM_PORTS*TYPE_W-1:0] resp_type,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic [POS_W-1:0]            mem_req_pos,
   input  logic                        mem_resp_valid,
   input  logic [TYPE_W-1:0]           mem_resp_type,
   input  logic                        upd_valid,
   input  logic [POS_W-1:0]            upd_pos,
   input  logic [TYPE_W-1:0]           upd_type,
   output logic [CNT_W-1:0]            hit_count,
   output logic [CNT_W-1:0]            miss_count
);

   localparam int SETS  = 1 << IDX_W;
   localparam int TAG_W = POS_W - IDX_W;
   localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int HN_W  = $clog2(NUM_PORTS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_FILL
   } miss_state_e;

   // ---------------------------------------------------------------------
   // Line storage (read combinationally by every port in parallel)
   // ---------------------------------------------------------------------
   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [TYPE_W-1:0] data_q [SETS];

   // Per-port request state
   logic [NUM_PORTS-1:0]        pend_q;
   logic [POS_W-1:0]            pos_q [NUM_PORTS];
   logic [NUM_PORTS-1:0]        resp_valid_q;
   logic [NUM_PORTS*TYPE_W-1:0] resp_type_q;

   // Miss engine state
   miss_state_e       state_q;
   logic [POS_W-1:0]  fetch_pos_q;
   logic              mem_req_valid_q;
   logic [PID_W-1:0]  last_q;
   logic              upd_pend_q;
   logic [TYPE_W-1:0] upd_hold_q;
   logic [CNT_W-1:0]  miss_cnt_q;
   logic [CNT_W-1:0]  hit_cnt_q;
   logic [CNT_W-1:0]  hit_cnt_d;

   // Lookup results
   logic [NUM_PORTS-1:0] hit_vec;
   logic [IDX_W-1:0]     lk_idx  [NUM_PORTS];
   logic [TYPE_W-1:0]    lk_data [NUM_PORTS];

   // Arbitration
   logic [NUM_PORTS-1:0] cand;
   logic                 grant_found;
   logic [PID_W-1:0]     grant_idx;

   // Fill / update write controls
   logic              fill_we;
   logic [IDX_W-1:0]  fill_idx;
   logic [TAG_W-1:0]  fill_tag;
   logic [TYPE_W-1:0] fill_data;
   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic [SETS-1:0]   fill_set;
   logic [SETS-1:0]   upd_set;

   // Hit accumulation
   logic [HN_W-1:0]  hit_num;
   logic [CNT_W:0]   hit_sum;

   // ---------------------------------------------------------------------
   // Per-port lookup
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_lookup
      assign lk_idx[gi]  = pos_q[gi][IDX_W-1:0];
      assign lk_data[gi] = data_q[lk_idx[gi]];
      assign hit_vec[gi] = pend_q[gi] & valid_q[lk_idx[gi]] &
                           (tag_q[lk_idx[gi]] == pos_q[gi][POS_W-1:IDX_W]);
   end

   // Pending ports that missed this cycle compete for the fetch channel.
   assign cand = pend_q & ~hit_vec;

   // Round-robin: search starts at the port after the last one granted.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         if (!grant_found && cand[(int'(last_q) + k) % NUM_PORTS]) begin
            grant_found = 1'b1;
            grant_idx   = PID_W'((int'(last_q) + k) % NUM_PORTS);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Fill and update write enables
   // ---------------------------------------------------------------------
   assign fill_we  = (state_q == S_WAIT) & mem_resp_valid;
   assign fill_idx = fetch_pos_q[IDX_W-1:0];
   assign fill_tag = fetch_pos_q[POS_W-1:IDX_W];
   // An edit to the in-flight position during WAIT supersedes the fetched data.
   assign fill_data = upd_pend_q ? upd_hold_q : mem_resp_type;
   assign upd_idx  = upd_pos[IDX_W-1:0];
   assign upd_tag  = upd_pos[POS_W-1:IDX_W];

   for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      logic             post_valid;
      logic [TAG_W-1:0] post_tag;
      assign fill_set[gi] = fill_we && (fill_idx == IDX_W'(gi));
      // The update is judged against the line as it looks after a same-cycle fill.
      assign post_valid   = fill_set[gi] | valid_q[gi];
      assign post_tag     = fill_set[gi] ? fill_tag : tag_q[gi];
      assign upd_set[gi]  = upd_valid && (upd_idx == IDX_W'(gi)) &&
                            post_valid && (post_tag == upd_tag);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_q | fill_set;
      end
   end

   always_ff @(posedge clk_in) begin
      for (int s = 0; s < SETS; s++) begin
         if (fill_set[s]) begin
            tag_q[s] <= fill_tag;
         end
         if (upd_set[s]) begin
            data_q[s] <= upd_type;
         end else if (fill_set[s]) begin
            data_q[s] <= fill_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Port state: IDLE (pend=0) / PEND (pend=1)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pend_q       <= '0;
         resp_valid_q <= '0;
         resp_type_q  <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            resp_valid_q[p] <= hit_vec[p];
            if (hit_vec[p]) begin
               resp_type_q[p*TYPE_W +: TYPE_W] <= lk_data[p];
               pend_q[p]                       <= 1'b0;
            end else if (!pend_q[p] && req_valid[p]) begin
               pend_q[p] <= 1'b1;
               pos_q[p]  <= req_pos[p*POS_W +: POS_W];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Miss engine: IDLE -> REQ -> WAIT -> FILL -> IDLE
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q         <= S_IDLE;
         mem_req_valid_q <= 1'b0;
         fetch_pos_q     <= '0;
         last_q          <= PID_W'(NUM_PORTS - 1);
         upd_pend_q      <= 1'b0;
         upd_hold_q      <= '0;
         miss_cnt_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_found) begin
                  fetch_pos_q     <= pos_q[grant_idx];
                  last_q          <= grant_idx;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  upd_pend_q      <= 1'b0;
                  if (miss_cnt_q != '1) begin
                     miss_cnt_q <= miss_cnt_q + 1'b1;
                  end
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  state_q <= S_FILL;
               end else if (upd_valid && (upd_pos == fetch_pos_q)) begin
                  upd_pend_q <= 1'b1;
                  upd_hold_q <= upd_type;
               end
            end
            S_FILL: begin
               upd_pend_q <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Hit counter: several ports may hit in the same cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      hit_num = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         hit_num = hit_num + HN_W'(hit_vec[p]);
      end
      hit_sum   = {1'b0, hit_cnt_q} + (CNT_W+1)'(hit_num);
      hit_cnt_d = hit_sum[CNT_W] ? '1 : hit_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign req_ready     = ~pend_q;
   assign resp_valid    = resp_valid_q;
   assign resp_type     = resp_type_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_req_pos   = fetch_pos_q;
   assign hit_count     = hit_cnt_q;
   assign miss_count    = miss_cnt_q;

endmodule
